// File: rtl/mul_arbiter.sv
// Round-robin front end for the shared 64x64 multiplier.
// Two requesters, start/wait/respond/clear sequencing, done watchdog.
module mul_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [63:0]  a0,
    input  logic [63:0]  b0,
    input  logic [63:0]  a1,
    input  logic [63:0]  b1,
    output logic         ack0,
    output logic         ack1,
    output logic         rsp_valid0,
    output logic         rsp_valid1,
    input  logic         rsp_ready0,
    input  logic         rsp_ready1,
    output logic [127:0] rsp_result,
    output logic         rsp_err,
    output logic         busy,
    output logic         m_op_start,
    output logic         m_op_clear,
    output logic [63:0]  m_multiplicand,
    output logic [63:0]  m_multiplier,
    input  logic         m_op_done,
    input  logic [127:0] m_result
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        RESP,
        CLEAR
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           gnt_id;
    logic           last_grant;
    logic           win;
    logic           wd_hit;
    logic [7:0]     wd_cnt;
    logic [63:0]    op_a;
    logic [63:0]    op_b;
    logic [127:0]   result_q;
    logic           err_q;

    // With both requesting, the one not served last wins
    assign win    = (req0 && req1) ? ~last_grant : req1;
    assign wd_hit = (wd_cnt == TIMEOUT - 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        m_op_start = 1'b0;
        m_op_clear = 1'b0;
        rsp_valid0 = 1'b0;
        rsp_valid1 = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (req0 || req1) state_nxt = START;
            end
            START: begin
                m_op_start = 1'b1;
                ack0       = ~gnt_id;
                ack1       = gnt_id;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (m_op_done || wd_hit) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid0 = ~gnt_id;
                rsp_valid1 = gnt_id;
                if (gnt_id ? rsp_ready1 : rsp_ready0) state_nxt = CLEAR;
            end
            CLEAR: begin
                m_op_clear = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_id     <= 1'b0;
            last_grant <= 1'b1;
            wd_cnt     <= 8'd0;
            op_a       <= 64'd0;
            op_b       <= 64'd0;
            result_q   <= 128'd0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_id     <= win;
                        last_grant <= win;
                        op_a       <= win ? a1 : a0;
                        op_b       <= win ? b1 : b0;
                    end
                end
                START: wd_cnt <= 8'd0;
                WAIT: begin
                    // done wins over a timeout landing on the same cycle
                    if (m_op_done) begin
                        result_q <= m_result;
                        err_q    <= 1'b0;
                    end else if (wd_hit) begin
                        result_q <= 128'd0;
                        err_q    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_multiplicand = op_a;
    assign m_multiplier   = op_b;
    assign rsp_result     = result_q;
    assign rsp_err        = err_q;

endmodule
